// File: rtl/cpu_pkg.sv
// Shared opcode map, FSM state codes and ACC mux selects for the CPU control unit.
// Optional feature macro CTRL_JMPC_EN: makes carry jumps 1001/1110 legal (they trap otherwise).
package cpu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_FETCH   = 2'd0;
  localparam state_t ST_DECODE  = 2'd1;
  localparam state_t ST_EXECUTE = 2'd2;
  localparam state_t ST_HALTED  = 2'd3;

  localparam logic [3:0] OP_NOP        = 4'b0000;
  localparam logic [3:0] OP_ADD        = 4'b0001;
  localparam logic [3:0] OP_SUB        = 4'b0010;
  localparam logic [3:0] OP_NOR        = 4'b0011;
  localparam logic [3:0] OP_SHFL       = 4'b0100;
  localparam logic [3:0] OP_SHFR       = 4'b0101;
  localparam logic [3:0] OP_REG_TO_ACC = 4'b0110;
  localparam logic [3:0] OP_IMM_TO_ACC = 4'b0111;
  localparam logic [3:0] OP_ACC_TO_REG = 4'b1000;
  localparam logic [3:0] OP_JMPC_REG   = 4'b1001;
  localparam logic [3:0] OP_JMPZ_REG   = 4'b1010;
  localparam logic [3:0] OP_JMPZ_IMM   = 4'b1011;
  localparam logic [3:0] OP_JMPNZ_REG  = 4'b1100;
  localparam logic [3:0] OP_JMPNZ_IMM  = 4'b1101;
  localparam logic [3:0] OP_JMPC_IMM   = 4'b1110;
  localparam logic [3:0] OP_HALT       = 4'b1111;

  localparam logic [1:0] SELACC_IMM = 2'b00;
  localparam logic [1:0] SELACC_REG = 2'b01;
  localparam logic [1:0] SELACC_ALU = 2'b11;

  // Wide enough to hold ALU_LAT-1 for the largest legal latency (8).
  localparam int CNT_W = 3;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NOR) ||
           (op == OP_SHFL) || (op == OP_SHFR);
  endfunction

  function automatic logic is_legal_op(input logic [3:0] op);
    logic ok;
    case (op)
`ifdef CTRL_JMPC_EN
      OP_JMPC_REG, OP_JMPC_IMM: ok = 1'b1;
`else
      OP_JMPC_REG, OP_JMPC_IMM: ok = 1'b0;
`endif
      default:                  ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/exec_cycle_counter.sv
// EXECUTE-phase down-counter: load on DECODE, decrement each EXECUTE cycle,
// 'last' high when the count has reached zero (final EXECUTE cycle).
module exec_cycle_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXECUTE/HALTED controller for the accumulator datapath.
// Optional feature macro CTRL_JMPC_EN (see cpu_pkg) enables carry-conditional jumps.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int OPC_W   = 4
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic [OPC_W-1:0] Opcode,
  input  logic             Z,
  input  logic             C,
  input  logic             ImemReady,
  output logic             LoadIR,
  output logic             IncPC,
  output logic             SelPC,
  output logic             LoadPC,
  output logic             LoadReg,
  output logic             LoadAcc,
  output logic [1:0]       SelAcc,
  output logic [OPC_W-1:0] SelALU,
  output logic             Halted,
  output logic             IllegalOp
);

  if ((ALU_LAT < 1) || (ALU_LAT > 8)) begin : g_bad_alu_lat
    $error("cpu_control_unit: ALU_LAT must be in 1..8");
  end
  if (OPC_W < 4) begin : g_bad_opc_w
    $error("cpu_control_unit: OPC_W must be at least 4");
  end

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  state_t           state_q, state_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             ill_q, ill_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_last;

  logic [3:0]       opc_in_lo;
  logic             opc_in_upper_nz;
  logic [3:0]       opc_lo;
  logic             take;

  assign opc_in_lo       = Opcode[3:0];
  assign opc_in_upper_nz = ((Opcode >> 4) != '0);
  assign opc_lo          = opc_q[3:0];

  exec_cycle_counter u_exec_cnt (
    .clk      (Clk),
    .rst_n    (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    z_d      = z_q;
    c_d      = c_q;
    ill_d    = ill_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (ImemReady) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opc_d = Opcode;
        z_d   = Z;
        c_d   = C;
        if (opc_in_upper_nz || !is_legal_op(opc_in_lo)) begin
          ill_d   = 1'b1;
          state_d = ST_HALTED;
        end else if (opc_in_lo == OP_HALT) begin
          state_d = ST_HALTED;
        end else begin
          // Non-ALU ops load zero so they leave EXECUTE after a single cycle.
          state_d  = ST_EXECUTE;
          cnt_load = 1'b1;
          cnt_val  = is_alu_op(opc_in_lo) ? CNT_INIT : '0;
        end
      end
      ST_EXECUTE: begin
        if (cnt_last) begin
          state_d = ST_FETCH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      opc_q   <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      ill_q   <= ill_d;
    end
  end

  // Outputs see only registered state; ImemReady is the sole live input, and it is
  // gated by reset_n so every strobe is low while reset is held.
  always_comb begin
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelAcc  = 2'b00;
    SelALU  = '0;
    take    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        LoadIR = ImemReady & reset_n;
      end
      ST_EXECUTE: begin
        case (opc_lo)
          OP_ADD, OP_SUB, OP_NOR, OP_SHFL, OP_SHFR: begin
            SelALU = opc_q;
            if (cnt_last) begin
              LoadAcc = 1'b1;
              SelAcc  = SELACC_ALU;
              IncPC   = 1'b1;
            end
          end
          OP_REG_TO_ACC: begin
            LoadAcc = 1'b1;
            SelAcc  = SELACC_REG;
            IncPC   = 1'b1;
          end
          OP_IMM_TO_ACC: begin
            LoadAcc = 1'b1;
            SelAcc  = SELACC_IMM;
            IncPC   = 1'b1;
          end
          OP_ACC_TO_REG: begin
            LoadReg = 1'b1;
            IncPC   = 1'b1;
          end
          OP_JMPZ_REG, OP_JMPZ_IMM, OP_JMPNZ_REG, OP_JMPNZ_IMM: begin
            take   = ((opc_lo == OP_JMPZ_REG) || (opc_lo == OP_JMPZ_IMM)) ? z_q : !z_q;
            SelPC  = (opc_lo == OP_JMPZ_IMM) || (opc_lo == OP_JMPNZ_IMM);
            LoadPC = take;
            IncPC  = !take;
          end
`ifdef CTRL_JMPC_EN
          OP_JMPC_REG, OP_JMPC_IMM: begin
            take   = c_q;
            SelPC  = (opc_lo == OP_JMPC_IMM);
            LoadPC = take;
            IncPC  = !take;
          end
`endif
          OP_NOP: begin
            IncPC = 1'b1;
          end
          default: begin
            IncPC = 1'b0;
          end
        endcase
      end
      default: begin
        LoadIR = 1'b0;
      end
    endcase
  end

  assign Halted    = (state_q == ST_HALTED);
  assign IllegalOp = ill_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit (ALU_LAT=3, OPC_W=5).
module tb_cpu_control_unit;

  localparam int OPC_W = 5;

  localparam logic [9:0] O_NONE    = 10'h000;
  localparam logic [9:0] O_LOADIR  = 10'h200;
  localparam logic [9:0] O_INCPC   = 10'h100;
  localparam logic [9:0] O_SELPC   = 10'h080;
  localparam logic [9:0] O_LOADPC  = 10'h040;
  localparam logic [9:0] O_LOADREG = 10'h020;
  localparam logic [9:0] O_LOADACC = 10'h010;
  localparam logic [9:0] O_ACC_ALU = 10'h00C;
  localparam logic [9:0] O_ACC_REG = 10'h004;
  localparam logic [9:0] O_HALTED  = 10'h002;
  localparam logic [9:0] O_ILL     = 10'h001;

  localparam logic [4:0] T_NOP   = 5'b00000;
  localparam logic [4:0] T_ADD   = 5'b00001;
  localparam logic [4:0] T_R2A   = 5'b00110;
  localparam logic [4:0] T_I2A   = 5'b00111;
  localparam logic [4:0] T_A2R   = 5'b01000;
  localparam logic [4:0] T_JCR   = 5'b01001;
  localparam logic [4:0] T_JZR   = 5'b01010;
  localparam logic [4:0] T_JZI   = 5'b01011;
  localparam logic [4:0] T_JNZR  = 5'b01100;
  localparam logic [4:0] T_JNZI  = 5'b01101;
  localparam logic [4:0] T_JCI   = 5'b01110;
  localparam logic [4:0] T_HALT  = 5'b01111;

  logic             Clk;
  logic             reset_n;
  logic [OPC_W-1:0] Opcode;
  logic             Z, C, ImemReady;
  logic             LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
  logic [1:0]       SelAcc;
  logic [OPC_W-1:0] SelALU;
  logic             Halted, IllegalOp;

  int errors = 0;
  int checks = 0;

  cpu_control_unit #(.ALU_LAT(3), .OPC_W(OPC_W)) dut (
    .Clk(Clk), .reset_n(reset_n), .Opcode(Opcode), .Z(Z), .C(C),
    .ImemReady(ImemReady), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
    .LoadPC(LoadPC), .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc),
    .SelALU(SelALU), .Halted(Halted), .IllegalOp(IllegalOp)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [9:0] obs();
    return {LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, SelAcc, Halted, IllegalOp};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0; ImemReady = 1'b0; Opcode = '0; Z = 1'b0; C = 1'b0;
    repeat (2) @(negedge Clk);
    reset_n = 1'b1;
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic step(input logic imem, input logic [OPC_W-1:0] op, input logic z, input logic c);
    @(negedge Clk);
    ImemReady = imem; Opcode = op; Z = z; C = c;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ImemReady = 1'b1; Opcode = T_ADD; Z = 1'b1; C = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if (obs() !== O_NONE) begin errors++; $display("FAIL reset_outs: got %h expected %h", obs(), O_NONE); end
    checks++;
    if (SelALU !== 5'd0) begin errors++; $display("FAIL reset_selalu: got %h expected 0", SelALU); end
    ImemReady = 1'b0;
    reset_n = 1'b1;
    step(1'b0, T_NOP, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_NONE) begin errors++; $display("FAIL post_reset_idle: got %h expected %h", obs(), O_NONE); end
  endtask

  task automatic test_alu_latency();
    logic [9:0] exp_o [6];
    logic [4:0] exp_a [6];
    logic [4:0] ops [5];
    exp_o = '{O_LOADIR, O_NONE, O_NONE, O_NONE, O_INCPC | O_LOADACC | O_ACC_ALU, O_LOADIR};
    ops   = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      exp_a = '{5'd0, 5'd0, ops[k], ops[k], ops[k], 5'd0};
      for (int cyc = 0; cyc < 6; cyc++) begin
        step(1'b1, ops[k], 1'b0, 1'b0);
        if (k == 0 || cyc >= 2) begin
          checks++;
          if (obs() !== exp_o[cyc]) begin
            errors++; $display("FAIL alu_op%0d_cyc%0d_outs: got %h expected %h", ops[k], cyc, obs(), exp_o[cyc]);
          end
          checks++;
          if (SelALU !== exp_a[cyc]) begin
            errors++; $display("FAIL alu_op%0d_cyc%0d_selalu: got %h expected %h", ops[k], cyc, SelALU, exp_a[cyc]);
          end
        end
      end
      do_reset();
    end
  endtask

  task automatic test_moves();
    logic [4:0] ops [4];
    logic [9:0] exp [4];
    ops = '{T_R2A, T_I2A, T_A2R, T_NOP};
    exp = '{O_INCPC | O_LOADACC | O_ACC_REG, O_INCPC | O_LOADACC, O_INCPC | O_LOADREG, O_INCPC};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ops[i], 1'b0, 1'b0);
      checks++;
      if (obs() !== O_LOADIR) begin errors++; $display("FAIL move%0d_fetch: got %h expected %h", i, obs(), O_LOADIR); end
      step(1'b1, ops[i], 1'b0, 1'b0);
      step(1'b1, ops[i], 1'b0, 1'b0);
      checks++;
      if (obs() !== exp[i]) begin errors++; $display("FAIL move%0d_exec: got %h expected %h", i, obs(), exp[i]); end
    end
  endtask

  task automatic test_jumps();
    logic [4:0] ops [6];
    logic       zs [6];
    logic [9:0] exp [6];
    ops = '{T_JZI, T_JZI, T_JZR, T_JZR, T_JNZR, T_JNZI};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp = '{O_LOADPC | O_SELPC, O_INCPC | O_SELPC, O_LOADPC, O_INCPC, O_LOADPC, O_INCPC | O_SELPC};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, ops[i], zs[i], 1'b0);
      step(1'b1, ops[i], zs[i], 1'b0);
      // Flip Z after DECODE: the jump must use the latched flag.
      step(1'b0, ops[i], ~zs[i], 1'b1);
      checks++;
      if (obs() !== exp[i]) begin errors++; $display("FAIL jump%0d_exec: got %h expected %h", i, obs(), exp[i]); end
    end
  endtask

  task automatic test_fetch_stall();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, T_ADD, 1'b1, 1'b1);
      checks++;
      if (obs() !== O_NONE) begin errors++; $display("FAIL stall_cyc%0d: got %h expected %h", i, obs(), O_NONE); end
    end
    step(1'b1, T_ADD, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_LOADIR) begin errors++; $display("FAIL stall_release: got %h expected %h", obs(), O_LOADIR); end
    step(1'b1, T_ADD, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_NONE) begin errors++; $display("FAIL stall_decode: got %h expected %h", obs(), O_NONE); end
  endtask

  task automatic test_jmpc();
    do_reset();
    step(1'b1, T_JCR, 1'b0, 1'b1);
    step(1'b1, T_JCR, 1'b0, 1'b1);
    step(1'b1, T_JCR, 1'b0, 1'b0);
`ifdef CTRL_JMPC_EN
    checks++;
    if (obs() !== O_LOADPC) begin errors++; $display("FAIL jmpc_reg_taken: got %h expected %h", obs(), O_LOADPC); end
    step(1'b1, T_JCI, 1'b0, 1'b0);
    step(1'b1, T_JCI, 1'b0, 1'b0);
    step(1'b1, T_JCI, 1'b0, 1'b1);
    checks++;
    if (obs() !== (O_INCPC | O_SELPC)) begin errors++; $display("FAIL jmpc_imm_not_taken: got %h expected %h", obs(), O_INCPC | O_SELPC); end
`else
    checks++;
    if (obs() !== (O_HALTED | O_ILL)) begin errors++; $display("FAIL jmpc_reg_illegal: got %h expected %h", obs(), O_HALTED | O_ILL); end
    do_reset();
    step(1'b1, T_JCI, 1'b0, 1'b1);
    step(1'b1, T_JCI, 1'b0, 1'b1);
    step(1'b1, T_JCI, 1'b0, 1'b1);
    checks++;
    if (obs() !== (O_HALTED | O_ILL)) begin errors++; $display("FAIL jmpc_imm_illegal: got %h expected %h", obs(), O_HALTED | O_ILL); end
`endif
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    step(1'b1, T_ADD, 1'b0, 1'b0);
    step(1'b1, T_ADD, 1'b0, 1'b0);
    step(1'b1, T_ADD, 1'b0, 1'b0);
    step(1'b1, T_ADD, 1'b0, 1'b0);
    checks++;
    if (SelALU !== 5'd1) begin errors++; $display("FAIL midrst_exec2_selalu: got %h expected 1", SelALU); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== O_NONE || SelALU !== 5'd0) begin
      errors++; $display("FAIL midrst_immediate: got %h/%h expected %h/0", obs(), SelALU, O_NONE);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      checks++;
      if (obs() !== O_NONE) begin errors++; $display("FAIL midrst_held%0d: got %h expected %h", i, obs(), O_NONE); end
    end
    ImemReady = 1'b0;
    reset_n = 1'b1;
    step(1'b1, T_NOP, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_LOADIR) begin errors++; $display("FAIL midrst_refetch: got %h expected %h", obs(), O_LOADIR); end
    step(1'b1, T_NOP, 1'b0, 1'b0);
    step(1'b1, T_NOP, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_INCPC) begin errors++; $display("FAIL midrst_nop_exec: got %h expected %h", obs(), O_INCPC); end
  endtask

  task automatic test_halt();
    logic [4:0] rop;
    do_reset();
    step(1'b1, T_HALT, 1'b0, 1'b0);
    step(1'b1, T_HALT, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_NONE) begin errors++; $display("FAIL halt_decode: got %h expected %h", obs(), O_NONE); end
    for (int i = 0; i < 20; i++) begin
      rop = 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (obs() !== O_HALTED || SelALU !== 5'd0) begin
        errors++; $display("FAIL halt_hold%0d: got %h/%h expected %h/0", i, obs(), SelALU, O_HALTED);
      end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (obs() !== O_NONE) begin errors++; $display("FAIL halt_reset_clears: got %h expected %h", obs(), O_NONE); end
    ImemReady = 1'b0;
    @(negedge Clk);
    reset_n = 1'b1;
    step(1'b1, T_NOP, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_LOADIR) begin errors++; $display("FAIL halt_refetch: got %h expected %h", obs(), O_LOADIR); end
  endtask

  task automatic test_illegal_upper();
    do_reset();
    step(1'b1, 5'b10001, 1'b0, 1'b0);
    step(1'b1, 5'b10001, 1'b0, 1'b0);
    checks++;
    if (obs() !== O_NONE) begin errors++; $display("FAIL illegal_decode: got %h expected %h", obs(), O_NONE); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, T_ADD, 1'b0, 1'b0);
      checks++;
      if (obs() !== (O_HALTED | O_ILL) || SelALU !== 5'd0) begin
        errors++; $display("FAIL illegal_sticky%0d: got %h/%h expected %h/0", i, obs(), SelALU, O_HALTED | O_ILL);
      end
    end
    do_reset();
    #1;
    checks++;
    if (IllegalOp !== 1'b0) begin errors++; $display("FAIL illegal_reset_clears: got %b expected 0", IllegalOp); end
  endtask

  initial begin
    reset_n = 1'b0; ImemReady = 1'b0; Opcode = '0; Z = 1'b0; C = 1'b0;
    test_reset();
    test_alu_latency();
    test_moves();
    test_jumps();
    test_fetch_stall();
    test_jmpc();
    test_reset_mid_exec();
    test_halt();
    test_illegal_upper();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 Parameter ALU_LAT, default 1, number of EXECUTE cycles for ALU opcodes; legal range 1..8.
REQ-002 Parameter OPC_W, default 4, opcode and SelALU width; opcode encodings occupy the low 4 bits, upper bits SHALL be zero for legal opcodes.
REQ-003 Clk  input  1  clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 Opcode  input  OPC_W  opcode from instruction register, valid during DECODE.
REQ-006 Z, C  input  1 each  zero/carry flags from ACC/ALU.
REQ-007 ImemReady  input  1  instruction memory data valid.
REQ-008 LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc  output  1 each  datapath strobes/selects, meanings unchanged from current controller.
REQ-009 SelAcc  output  2  ACC mux select; SelALU  output  OPC_W  ALU operation.
REQ-010 Halted  output  1  core stopped; IllegalOp  output  1  sticky illegal-opcode trap.

Function
REQ-011 FSM states SHALL be FETCH, DECODE, EXECUTE, HALTED.
REQ-012 FETCH: hold until ImemReady=1; in the ready cycle assert LoadIR=1 and go to DECODE.
REQ-013 DECODE: one cycle, all strobes 0; latch Opcode, Z, C into internal registers; go to HALTED if opcode is HALT (1111) or illegal, else EXECUTE.
REQ-014 EXECUTE for ADD/SUB/NOR/SHFL/SHFR: stay ALU_LAT cycles via down-counter; SelALU=latched opcode every cycle; only last cycle asserts LoadAcc=1, SelAcc=11, IncPC=1; then FETCH.
REQ-015 EXECUTE for REG_TO_ACC (SelAcc=01), IMM_TO_ACC (SelAcc=00): one cycle, LoadAcc=1, IncPC=1.
REQ-016 EXECUTE for ACC_TO_REG: one cycle, LoadReg=1, IncPC=1; NOP: one cycle, IncPC=1 only.
REQ-017 Jumps evaluated on latched flags: JMPZ_* taken iff Z=1, JMPNZ_* taken iff Z=0; taken -> LoadPC=1, IncPC=0; not taken -> IncPC=1, LoadPC=0; SelPC=0 for *_REG, 1 for *_IMM; one cycle.
REQ-018 LoadPC and IncPC SHALL never both be 1; no output SHALL ever be X; unused selects drive 0.
REQ-019 SelALU SHALL be 0 outside EXECUTE.
REQ-020 Illegal opcode (unlisted encoding, or nonzero upper bits) SHALL set IllegalOp=1 and enter HALTED with no strobe issued.
REQ-021 HALTED is terminal until reset; Halted=1, all strobes 0.
REQ-022 Outputs SHALL be decoded from registered state, latched opcode, latched flags and counter only (no Opcode/Z/C combinational path to outputs).

Reset
REQ-023 reset_n=0 SHALL immediately force state FETCH, counter 0, latched opcode/flags 0, IllegalOp=0, all outputs 0, including mid-EXECUTE.
REQ-024 First FETCH completes no earlier than the first rising edge after reset_n deasserts.

Configuration
REQ-025 Macro CTRL_JMPC_EN defined: opcodes 1001 (JMPC_REG) and 1110 (JMPC_IMM) are legal, taken iff latched C=1, otherwise behaving as REQ-017.
REQ-026 Macro CTRL_JMPC_EN undefined: 1001 and 1110 are illegal per REQ-020.

Structure
REQ-027 Opcode constants, state encoding and SelAcc encodings SHALL live in shared package cpu_pkg.
REQ-028 ALU latency counter SHALL be sub-module exec_cycle_counter (load, decrement, last flag).

Verification
REQ-029 ADD, ALU_LAT=3, ImemReady=1 -> LoadIR cycle 0, DECODE cycle 1, LoadAcc=1/SelAcc=11/IncPC=1 only in cycle 4, LoadIR again cycle 5.
REQ-030 JMPZ_IMM with Z=1 -> LoadPC=1, SelPC=1, IncPC=0; repeat with Z=0 -> IncPC=1, LoadPC=0.
REQ-031 ImemReady=0 for 5 cycles in FETCH -> no strobes, LoadIR=1 in the cycle ImemReady rises.
REQ-032 Opcode 1001 -> with CTRL_JMPC_EN and C=1: LoadPC=1, SelPC=0; without macro: IllegalOp=1, Halted=1 after DECODE.
REQ-033 reset_n pulled low in the second of 3 ALU EXECUTE cycles -> outputs 0 immediately, LoadAcc never asserted, FETCH resumes after release.
REQ-034 HALT -> Halted=1 held for 20 cycles regardless of ImemReady/Opcode, cleared only by reset_n.
